// File: rtl/axis_util_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter: FSM state encoding
// and a constant-width helper.
package axis_util_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Signal bundle between the N slave streams, the merged master stream and the arbiter.
// The arbiter attaches through 'slave'; whatever drives and observes the streams attaches through 'master'.
interface axis_packet_arbiter_if #(
  parameter int AXIS_TDATA_WIDTH = 8,
  parameter int NUM_INPUTS       = 3,
  parameter int IDX_WIDTH        = 3
) ();

  logic [NUM_INPUTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_INPUTS-1:0]                  s_axis_tvalid;
  logic [NUM_INPUTS-1:0]                  s_axis_tlast;
  logic [NUM_INPUTS-1:0]                  s_axis_tready;
  logic [AXIS_TDATA_WIDTH-1:0]            m_axis_tdata;
  logic                                   m_axis_tvalid;
  logic                                   m_axis_tlast;
  logic [IDX_WIDTH-1:0]                   m_axis_tid;
  logic                                   m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

endinterface

// File: rtl/axis_packet_arbiter_rr_pick.sv
// Combinational round-robin search: first requester after i_last_idx, wrapping
// modulo NUM_INPUTS, so a lone requester finds itself again.
module rr_pick #(
  parameter int NUM_INPUTS = 3,
  parameter int IDX_WIDTH  = 3
) (
  input  logic [NUM_INPUTS-1:0] i_req,
  input  logic [IDX_WIDTH-1:0]  i_last_idx,
  output logic [IDX_WIDTH-1:0]  o_idx,
  output logic                  o_found
);

  int w_dist;
  int w_best;

  // Distance is how far past i_last_idx an input sits; the smallest requesting distance wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_dist  = 0;
    w_best  = NUM_INPUTS;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_dist = (i + NUM_INPUTS * (1 << IDX_WIDTH) - int'(i_last_idx) - 1) % NUM_INPUTS;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_idx   = IDX_WIDTH'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-locked round-robin merge of NUM_INPUTS AXI-Stream slaves into one
// registered master stream tagged with the source index.
module axis_packet_arbiter
  import axis_util_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 8,
  parameter int NUM_INPUTS       = 3,
  parameter int IDX_WIDTH        = 3
) (
  input  logic                   axis_aclk,
  input  logic                   axis_areset,
  axis_packet_arbiter_if.slave   bus,
  output logic                   grant_active
);

  arb_state_t                  r_state;
  arb_state_t                  w_state_next;
  logic [IDX_WIDTH-1:0]        r_grant_idx;
  logic [IDX_WIDTH-1:0]        r_last_idx;
  logic [IDX_WIDTH-1:0]        w_pick_idx;
  logic                        w_found;
  logic [AXIS_TDATA_WIDTH-1:0] w_sel_tdata;
  logic                        w_sel_tvalid;
  logic                        w_sel_tlast;
  logic                        w_out_free;
  logic                        w_accept;
  logic                        w_grant_load;
  logic                        w_packet_done;
  logic [NUM_INPUTS-1:0]       w_s_tready;
  logic [AXIS_TDATA_WIDTH-1:0] r_m_tdata;
  logic                        r_m_tvalid;
  logic                        r_m_tlast;
  logic [IDX_WIDTH-1:0]        r_m_tid;

  rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_rr_pick (
    .i_req      (bus.s_axis_tvalid),
    .i_last_idx (r_last_idx),
    .o_idx      (w_pick_idx),
    .o_found    (w_found)
  );

  always_comb begin
    w_sel_tdata  = '0;
    w_sel_tvalid = 1'b0;
    w_sel_tlast  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (IDX_WIDTH'(i) == r_grant_idx) begin
        w_sel_tdata  = bus.s_axis_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
        w_sel_tvalid = bus.s_axis_tvalid[i];
        w_sel_tlast  = bus.s_axis_tlast[i];
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) r_state <= ST_IDLE;
    else             r_state <= w_state_next;
  end

  // Reset also masks the slave handshake so a partial packet cannot advance in the reset cycle.
  always_comb begin
    w_state_next  = r_state;
    w_s_tready    = '0;
    w_accept      = 1'b0;
    w_grant_load  = 1'b0;
    w_packet_done = 1'b0;
    w_out_free    = bus.m_axis_tready | ~r_m_tvalid;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_next = ST_GRANT;
          w_grant_load = 1'b1;
        end
      end
      ST_GRANT: begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (IDX_WIDTH'(i) == r_grant_idx) w_s_tready[i] = w_out_free;
        end
        w_accept = w_sel_tvalid & w_out_free;
        if (w_accept && w_sel_tlast) begin
          w_state_next  = ST_IDLE;
          w_packet_done = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (axis_areset) begin
      w_s_tready = '0;
      w_accept   = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_grant_idx <= '0;
      r_last_idx  <= IDX_WIDTH'(NUM_INPUTS - 1);
    end else begin
      if (w_grant_load)  r_grant_idx <= w_pick_idx;
      if (w_packet_done) r_last_idx  <= r_grant_idx;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
    end else if (w_accept) begin
      r_m_tdata  <= w_sel_tdata;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_sel_tlast;
      r_m_tid    <= r_grant_idx;
    end else if (bus.m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign bus.s_axis_tready = w_s_tready;
  assign bus.m_axis_tdata  = r_m_tdata;
  assign bus.m_axis_tvalid = r_m_tvalid & ~axis_areset;
  assign bus.m_axis_tlast  = r_m_tlast;
  assign bus.m_axis_tid    = r_m_tid;
  assign grant_active      = (r_state == ST_GRANT) & ~axis_areset;

endmodule
